// File: rtl/uart_mmio_buffer_if.sv
// CPU-side strobes and UART byte handshakes for uart_mmio_buffer.
// The buffer uses the slave modport; whoever drives the CPU strobes and the serial side uses master.
interface uart_mmio_buffer_if;
  logic        REUART;
  logic        WEUART;
  logic [1:0]  UARTsel;
  logic [7:0]  WriteData;
  logic [31:0] ReadData;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic        DataOutReady;

  modport slave (
    input  REUART, WEUART, UARTsel, WriteData, DataInReady, DataOut, DataOutValid,
    output ReadData, DataIn, DataInValid, DataOutReady
  );
  modport master (
    output REUART, WEUART, UARTsel, WriteData, DataInReady, DataOut, DataOutValid,
    input  ReadData, DataIn, DataInValid, DataOutReady
  );
endinterface

// File: rtl/uart_mmio_buffer.sv
// MMIO UART buffer: RX FIFO plus a TX path, with a registered load result timed for writeback.
// UART_TX_FIFO_EN selects a TX_DEPTH-entry TX FIFO; without it, TX is a single holding register.
module uart_mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Push/pop are pre-qualified by the caller against full/empty.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end

  assign head = mem[rptr];
endmodule

module uart_mmio_buffer #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic               Clock,
  input  logic               reset_n,
  uart_mmio_buffer_if.slave  bus
);
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
      TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_mmio_buffer: FIFO depths must be powers of 2 and >= 2");
  end

  logic [7:0]      rx_head, tx_head, rx_cnt8;
  logic [RXCW-1:0] rx_count;
  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic            rd_rx, rd_status, tx_store, tx_ready, tx_push, tx_pop, tx_empty;
  logic            tx_overflow;
  logic [31:0]     rdata;

  // All ready/full decisions use start-of-cycle counts, so a full FIFO refuses a same-edge push.
  assign rx_full           = rx_count == RXCW'(RX_DEPTH);
  assign rx_empty          = rx_count == '0;
  assign rx_cnt8           = 8'(rx_count);
  assign bus.DataOutReady  = !rx_full;
  assign rx_push           = bus.DataOutValid && !rx_full;
  assign rd_rx             = bus.REUART && bus.UARTsel == 2'b00;
  assign rd_status         = bus.REUART && bus.UARTsel == 2'b01;
  assign rx_pop            = rd_rx && !rx_empty;
  assign tx_store          = bus.WEUART && bus.UARTsel == 2'b10;
  assign tx_push           = tx_store && tx_ready;
  assign tx_pop            = !tx_empty && bus.DataInReady;

  uart_mmio_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk   (Clock),
    .rst_n (reset_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (bus.DataOut),
    .head  (rx_head),
    .count (rx_count)
  );

`ifdef UART_TX_FIFO_EN
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  logic [TXCW-1:0] tx_count;

  uart_mmio_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk   (Clock),
    .rst_n (reset_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.WriteData),
    .head  (tx_head),
    .count (tx_count)
  );

  assign tx_empty = tx_count == '0;
  assign tx_ready = tx_count != TXCW'(TX_DEPTH);
`else
  logic tx_vld;

  // Push and pop are mutually exclusive here: push needs an empty slot, pop needs a full one.
  always_ff @(posedge Clock or negedge reset_n)
    if (!reset_n) begin
      tx_vld  <= 1'b0;
      tx_head <= 8'h00;
    end else if (tx_push) begin
      tx_vld  <= 1'b1;
      tx_head <= bus.WriteData;
    end else if (tx_pop) begin
      tx_vld  <= 1'b0;
    end

  assign tx_empty = !tx_vld;
  assign tx_ready = !tx_vld;
`endif

  assign bus.DataInValid = !tx_empty;
  assign bus.DataIn      = tx_empty ? 8'h00 : tx_head;

  // A drop on the same edge as a status read must survive to be reported by the next read.
  always_ff @(posedge Clock or negedge reset_n)
    if (!reset_n) begin
      tx_overflow <= 1'b0;
      rdata       <= '0;
    end else begin
      if (tx_store && !tx_ready) tx_overflow <= 1'b1;
      else if (rd_status)        tx_overflow <= 1'b0;
      if (bus.REUART) begin
        case (bus.UARTsel)
          2'b00:   rdata <= rx_empty ? 32'h0 : {24'h0, rx_head};
          2'b01:   rdata <= {16'h0, rx_cnt8, 5'b0, tx_overflow, !rx_empty, tx_ready};
          default: rdata <= 32'h0;
        endcase
      end
    end

  assign bus.ReadData = rdata;
endmodule
